// File: rtl/tns_decoder_27_pkg.sv
// Shared TNS constants for the 27-bit codec: codeword length, data width, bit weights.
// Weights follow the tribonacci series (1, 2, 4, 7, 13, ...) from bit 0 upward.
package tns_decoder_27_pkg;

   localparam int TNS_CW_LEN = 27;
   localparam int BLEN09     = 24;
   localparam int TNS_NGRP   = 9;

   typedef logic [BLEN09-1:0] tns_word_t;

   typedef struct packed {
      tns_word_t a;
      tns_word_t b;
      tns_word_t c;
   } tns_grp_w_t;

   // Weight of codeword bit j; each weight is the sum of the three below it.
   function automatic tns_word_t tns_bit_w(input int j);
      tns_word_t w0;
      tns_word_t w1;
      tns_word_t w2;
      tns_word_t wn;
      tns_word_t res;
      w0 = tns_word_t'(1);
      w1 = tns_word_t'(2);
      w2 = tns_word_t'(4);
      wn = '0;
      for (int i = 3; i <= j; i++) begin
         wn = w0 + w1 + w2;
         w0 = w1;
         w1 = w2;
         w2 = wn;
      end
      if (j == 0)      res = w0;
      else if (j == 1) res = w1;
      else             res = w2;
      return res;
   endfunction

   localparam tns_word_t TNS01_A = tns_bit_w(2);
   localparam tns_word_t TNS01_B = tns_bit_w(1);
   localparam tns_word_t TNS01_C = tns_bit_w(0);
   localparam tns_word_t TNS02_A = tns_bit_w(5);
   localparam tns_word_t TNS02_B = tns_bit_w(4);
   localparam tns_word_t TNS02_C = tns_bit_w(3);
   localparam tns_word_t TNS03_A = tns_bit_w(8);
   localparam tns_word_t TNS03_B = tns_bit_w(7);
   localparam tns_word_t TNS03_C = tns_bit_w(6);
   localparam tns_word_t TNS04_A = tns_bit_w(11);
   localparam tns_word_t TNS04_B = tns_bit_w(10);
   localparam tns_word_t TNS04_C = tns_bit_w(9);
   localparam tns_word_t TNS05_A = tns_bit_w(14);
   localparam tns_word_t TNS05_B = tns_bit_w(13);
   localparam tns_word_t TNS05_C = tns_bit_w(12);
   localparam tns_word_t TNS06_A = tns_bit_w(17);
   localparam tns_word_t TNS06_B = tns_bit_w(16);
   localparam tns_word_t TNS06_C = tns_bit_w(15);
   localparam tns_word_t TNS07_A = tns_bit_w(20);
   localparam tns_word_t TNS07_B = tns_bit_w(19);
   localparam tns_word_t TNS07_C = tns_bit_w(18);
   localparam tns_word_t TNS08_A = tns_bit_w(23);
   localparam tns_word_t TNS08_B = tns_bit_w(22);
   localparam tns_word_t TNS08_C = tns_bit_w(21);
   localparam tns_word_t TNS09_A = tns_bit_w(26);
   localparam tns_word_t TNS09_B = tns_bit_w(25);
   localparam tns_word_t TNS09_C = tns_bit_w(24);

   // Per-group weight set (k = 1..9); group 1 uses weight 1 for bit 0.
   function automatic tns_grp_w_t tns_grp_w(input int k);
      tns_grp_w_t gw;
      gw.a = tns_bit_w(3*k - 1);
      gw.b = tns_bit_w(3*k - 2);
      gw.c = (k == 1) ? tns_word_t'(1) : tns_bit_w(3*k - 3);
      return gw;
   endfunction

endpackage

// File: rtl/tns_decoder_27_group_sum.sv
// One 3-bit TNS group: adds the weights of the set bits (combinational).
module tns_group_sum
   import tns_decoder_27_pkg::*;
(
   input  logic [2:0] bits,
   input  tns_grp_w_t w,
   output tns_word_t  psum
);

   assign psum = (bits[2] ? w.a : '0)
               + (bits[1] ? w.b : '0)
               + (bits[0] ? w.c : '0);

endmodule

// File: rtl/tns_decoder_27.sv
// 27-bit TNS codeword decoder: 4-register weighted-sum pipeline with valid/ready flow control.
// Optional crosstalk-violation flag on xt_err when TNS_XTALK_CHECK_EN is defined.
module tns_decoder_27
   import tns_decoder_27_pkg::*;
(
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic [TNS_CW_LEN-1:0] code_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [BLEN09-1:0]     data_out,
   output logic                  out_valid,
   input  logic                  out_ready
`ifdef TNS_XTALK_CHECK_EN
   ,
   output logic                  xt_err
`endif
);

   // Handshake: a word moves on valid && ready at either port; the whole
   // pipeline freezes only while the output holds a word the sink refuses.
   logic stall;
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   logic                               s1_v;
   logic [TNS_CW_LEN-1:0]              s1_code;
   logic                               s2_v;
   logic [TNS_NGRP-1:0][BLEN09-1:0]    s2_p;
   logic                               s3_v;
   logic [2:0][BLEN09-1:0]             s3_s;
   logic [TNS_NGRP-1:0][BLEN09-1:0]    grp_sum;

   for (genvar g = 0; g < TNS_NGRP; g++) begin : g_grp
      localparam tns_grp_w_t GW = tns_grp_w(g + 1);
      tns_group_sum u_grp (
         .bits (s1_code[3*g+2 -: 3]),
         .w    (GW),
         .psum (grp_sum[g])
      );
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_code   <= '0;
         s2_v      <= 1'b0;
         s2_p      <= '0;
         s3_v      <= 1'b0;
         s3_s      <= '0;
         out_valid <= 1'b0;
         data_out  <= '0;
      end else if (!stall) begin
         s1_v    <= in_valid;
         s1_code <= code_in;
         s2_v    <= s1_v;
         s2_p    <= grp_sum;
         s3_v    <= s2_v;
         for (int j = 0; j < 3; j++) begin
            s3_s[j] <= s2_p[3*j] + s2_p[3*j+1] + s2_p[3*j+2];
         end
         out_valid <= s3_v;
         data_out  <= s3_s[0] + s3_s[1] + s3_s[2];
      end
   end

`ifdef TNS_XTALK_CHECK_EN
   logic [TNS_CW_LEN-1:0] prev_code;
   logic [TNS_CW_LEN-1:0] rise;
   logic [TNS_CW_LEN-1:0] fall;
   logic                  xt_now;
   logic                  s1_xt;
   logic                  s2_xt;
   logic                  s3_xt;

   // Opposite transitions on neighbouring wires are the worst-case coupling pattern.
   assign rise   = code_in & ~prev_code;
   assign fall   = prev_code & ~code_in;
   assign xt_now = |((rise[TNS_CW_LEN-2:0] & fall[TNS_CW_LEN-1:1]) |
                     (fall[TNS_CW_LEN-2:0] & rise[TNS_CW_LEN-1:1]));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         prev_code <= '0;
         s1_xt     <= 1'b0;
         s2_xt     <= 1'b0;
         s3_xt     <= 1'b0;
         xt_err    <= 1'b0;
      end else if (!stall) begin
         if (in_valid) begin
            prev_code <= code_in;
         end
         s1_xt  <= in_valid && xt_now;
         s2_xt  <= s1_xt;
         s3_xt  <= s2_xt;
         xt_err <= s3_xt;
      end
   end
`endif

endmodule

// File: tb/tb_tns_decoder_27.sv
// Bench for tns_decoder_27: vector table, hand sequences for latency/stall/reset, and a
// randomized round trip through a greedy TNS encoder model. Define TNS_XTALK_CHECK_EN to cover xt_err.
module tb_tns_decoder_27;

   localparam int W  = 24;
   localparam int CW = 27;
   localparam int unsigned DMAX = 15902590;

   logic          clock = 1'b0;
   logic          rst_n = 1'b1;
   logic [CW-1:0] code_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  data_out;
   logic          out_valid;
   logic          out_ready;
`ifdef TNS_XTALK_CHECK_EN
   logic          xt_err;
`endif

   int   bp_mode = 0;
   logic rnd_ready = 1'b1;
   assign out_ready = (bp_mode == 0) ? 1'b1 : (bp_mode == 1) ? rnd_ready : 1'b0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
   end

   tns_decoder_27 dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .code_in   (code_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_out  (data_out),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef TNS_XTALK_CHECK_EN
      ,
      .xt_err    (xt_err)
`endif
   );

   int            tests = 0;
   int            fails = 0;
   logic [W-1:0]  exp_q[$];
   logic          xt_q[$];
   logic [CW-1:0] model_prev = '0;
   logic [W-1:0]  w_tab [CW];

   typedef struct {
      logic [CW-1:0] code;
      logic [W-1:0]  exp_d;
   } vec_t;
   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference decode: sum of tribonacci weights of the set bits, modulo 2^W.
   function automatic logic [W-1:0] ref_sum(input logic [CW-1:0] c);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < CW; i++) begin
         if (c[i]) acc = acc + {8'd0, w_tab[i]};
      end
      return acc[W-1:0];
   endfunction

   // Encoder model: greedy representation from the heaviest bit down.
   function automatic logic [CW-1:0] encode(input int unsigned d);
      logic [CW-1:0] c;
      int unsigned   rem;
      c   = '0;
      rem = d;
      for (int j = CW - 1; j >= 0; j--) begin
         if (rem >= {8'd0, w_tab[j]}) begin
            c[j] = 1'b1;
            rem  = rem - {8'd0, w_tab[j]};
         end
      end
      return c;
   endfunction

   function automatic logic xt_model(input logic [CW-1:0] p, input logic [CW-1:0] c);
      logic hit;
      bit   up_i, dn_i, up_j, dn_j;
      hit = 1'b0;
      for (int i = 0; i < CW - 1; i++) begin
         up_i = !p[i] && c[i];
         dn_i = p[i] && !c[i];
         up_j = !p[i+1] && c[i+1];
         dn_j = p[i+1] && !c[i+1];
         if ((up_i && dn_j) || (dn_i && up_j)) hit = 1'b1;
      end
      return hit;
   endfunction

   // Present one word until accepted; force_x < 0 takes the expected flag from the model.
   task automatic send(input logic [CW-1:0] code, input logic [W-1:0] exp_d,
                       input bit push, input int force_x);
      logic x;
      bit   done;
      done = 1'b0;
      x    = (force_x < 0) ? xt_model(model_prev, code) : force_x[0];
      code_in  = code;
      in_valid = 1'b1;
      for (int t = 0; t < 300 && !done; t++) begin
         @(negedge clock);
         if (in_ready) begin
            if (push) begin
               exp_q.push_back(exp_d);
               xt_q.push_back(x);
            end
            model_prev = code;
            done = 1'b1;
         end
         @(posedge clock);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: in_ready stayed 0 for code %h", code);
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 500 && exp_q.size() != 0; t++) begin
         @(posedge clock);
         #1;
      end
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d words outstanding, expected 0", exp_q.size());
      end
   endtask

   // Accepting edge counts as edge 1; out_valid must be a one-cycle pulse after edge 4.
   task automatic check_latency(input logic [CW-1:0] code, input logic [W-1:0] exp_d,
                                input string name);
      code_in  = code;
      in_valid = 1'b1;
      check({name, "_in_ready"}, in_ready, 1);
      exp_q.push_back(exp_d);
      xt_q.push_back(xt_model(model_prev, code));
      model_prev = code;
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         check($sformatf("%s_valid_e%0d", name, k), out_valid, (k == 4));
         if (k == 4) check({name, "_data"}, data_out, exp_d);
         @(posedge clock);
         #1;
      end
   endtask

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   logic         held_v = 1'b0;
   logic [W-1:0] held_d = '0;
`ifdef TNS_XTALK_CHECK_EN
   logic         held_x = 1'b0;
`endif
   always @(negedge clock) begin
      if (!rst_n) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("stall_hold_valid", out_valid, 1);
            check("stall_hold_data", data_out, held_d);
`ifdef TNS_XTALK_CHECK_EN
            check("stall_hold_xt", xt_err, held_x);
`endif
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_out: data %0d delivered, expected no word", data_out);
            end else begin
               check("data_out", data_out, exp_q.pop_front());
               if (xt_q.size() != 0) begin
`ifdef TNS_XTALK_CHECK_EN
                  check("xt_err", xt_err, xt_q.pop_front());
`else
                  void'(xt_q.pop_front());
`endif
               end
            end
         end
         held_v = out_valid && !out_ready;
         held_d = data_out;
`ifdef TNS_XTALK_CHECK_EN
         held_x = xt_err;
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned   d;
      logic [31:0]   r;
      logic [CW-1:0] c;
      bit            stall_seen;

      w_tab[0] = 24'd1;
      w_tab[1] = 24'd2;
      w_tab[2] = 24'd4;
      for (int i = 3; i < CW; i++) w_tab[i] = w_tab[i-1] + w_tab[i-2] + w_tab[i-3];

      vecs[0]  = '{27'h0000000, 24'd0};
      vecs[1]  = '{27'h0000001, 24'd1};
      vecs[2]  = '{27'h0000002, 24'd2};
      vecs[3]  = '{27'h0000008, 24'd7};
      vecs[4]  = '{27'h0000010, 24'd13};
      vecs[5]  = '{27'h0000007, 24'd7};
      vecs[6]  = '{27'h0000015, 24'd18};
      vecs[7]  = '{27'h1000000, 24'd2555757};
      vecs[8]  = '{27'h2000000, 24'd4700770};
      vecs[9]  = '{27'h4000000, 24'd8646064};
      vecs[10] = '{27'h6000000, 24'd13346834};
      vecs[11] = '{27'h5000001, 24'd11201822};

      // Reset state
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_data_out", data_out, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clock);
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // Zero codeword: 4-edge latency, single-cycle pulse
      check_latency(27'h0, 24'd0, "zero");

      // Bit 0 then bit 26 on consecutive cycles
      send(27'h0000001, 24'd1, 1'b1, -1);
      send(27'h4000000, 24'd8646064, 1'b1, -1);
      repeat (2) begin
         @(posedge clock);
         #1;
      end
      check("consec_first_valid", out_valid, 1);
      check("consec_first_data", data_out, 1);
      @(posedge clock);
      #1;
      check("consec_second_valid", out_valid, 1);
      check("consec_second_data", data_out, 24'd8646064);
      drain();

      // Vector table, back to back
      for (int i = 0; i < 12; i++) send(vecs[i].code, vecs[i].exp_d, 1'b1, -1);
      drain();

`ifdef TNS_XTALK_CHECK_EN
      send(27'h1, 24'd1, 1'b1, -1);
      send(27'h2, 24'd2, 1'b1, 1);
      send(27'h1, 24'd1, 1'b1, -1);
      send(27'h3, 24'd3, 1'b1, 0);
      drain();
`endif

      // Round trip with random backpressure
      bp_mode = 1;
      for (int n = 0; n < 2000; n++) begin
         d = $urandom_range(0, DMAX);
         send(encode(d), d[W-1:0], 1'b1, -1);
      end
      bp_mode = 0;
      drain();

      // Six-word stream with a 5-cycle stall once output is valid
      stall_seen = 1'b0;
      fork
         begin
            for (int n = 0; n < 6; n++) begin
               r = $urandom();
               c = r[CW-1:0];
               send(c, ref_sum(c), 1'b1, -1);
            end
         end
         begin
            for (int t = 0; t < 50 && !stall_seen; t++) begin
               @(posedge clock);
               #1;
               if (out_valid) stall_seen = 1'b1;
            end
            check("bp_out_valid_seen", stall_seen, 1);
            bp_mode = 2;
            for (int k = 0; k < 5; k++) begin
               @(negedge clock);
               check("bp_in_ready_low", in_ready, 0);
               @(posedge clock);
               #1;
            end
            bp_mode = 0;
         end
      join
      drain();

      // Reset with three words in flight
      for (int n = 0; n < 3; n++) begin
         d = $urandom_range(1, DMAX);
         send(encode(d), d[W-1:0], 1'b0, -1);
      end
      @(posedge clock);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_data_out", data_out, 0);
      exp_q.delete();
      xt_q.delete();
      model_prev = '0;
      repeat (2) @(posedge clock);
      #1;
      rst_n = 1'b1;
      @(posedge clock);
      #1;
      d = $urandom_range(1, DMAX);
      check_latency(encode(d), d[W-1:0], "post_midrst");
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
